exhaustive_sweep_engine: RTL and testbench
==========================================

Name: exhaustive_sweep_engine

Overview:
- Synthesizable successor to our bench-driven exhaustive input sweeps for trojan-detection benchmarks.
- Drives every one of the 2^N_IN input vectors into a DUT, in binary or Gray order, and samples the DUT response after a programmable settle time.
- Streams (vector, response) records over a valid/ready handshake and folds all responses into a MISR signature for golden-vs-suspect comparison.
- Sits between the benchmark instance and the capture/log path.

Parameters:
- N_IN, 5, DUT input width (1..16).
- N_OUT, 1, DUT response width (1..MISR_W).
- SETTLE, 1, cycles each vector is held before sampling (>=1).
- MISR_W, 16, signature width.
- MISR_POLY, 16'h1021, Galois feedback polynomial (MISR_W bits).

Ports:
- CK  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to begin a sweep; ignored unless idle or done.
- mode  in  1  sampled at start: 0 = ascending binary order, 1 = Gray order (g = i ^ (i>>1)).
- abort  in  1  terminate the sweep; takes effect the same cycle it is seen.
- vec_out  out  N_IN  vector applied to the DUT.
- dut_resp  in  N_OUT  DUT response.
- rec_valid  out  1  record available.
- rec_ready  in  1  consumer accepts the record.
- rec_vec  out  N_IN  vector of the record.
- rec_resp  out  N_OUT  sampled response of the record.
- busy  out  1  sweep in progress.
- done  out  1  sweep completed normally; level, held until next start or reset.
- aborted  out  1  last sweep was aborted; level, held until next start or reset.
- signature  out  MISR_W  MISR value; valid when done=1.
- vec_count  out  N_IN+1  number of records accepted so far.

Behaviour:
- Reset (reset=0 at a CK edge):
  - state=IDLE.
  - All outputs 0: vec_out, rec_*, busy, done, aborted, signature, vec_count.
  - Reset mid-sweep discards everything, with no final record.
- FSM states: IDLE, APPLY, EMIT, DONE.
- IDLE/DONE, start=1:
  - Clears signature, vec_count, done and aborted; latches mode; index i=0.
  - Next cycle: APPLY, vec_out=order(0), busy=1.
- APPLY:
  - vec_out held for exactly SETTLE cycles.
  - On the last APPLY cycle, dut_resp is registered into rec_resp, rec_vec=vec_out, and the MISR updates:
    - fb = sig[MISR_W-1];
    - sig = ({sig[MISR_W-2:0],0} ^ (fb ? MISR_POLY : 0)) ^ zero_ext(dut_resp).
  - Next state: EMIT.
- EMIT:
  - rec_valid=1; rec_vec and rec_resp are stable while rec_valid=1 and rec_ready=0.
  - vec_out stays at the current vector during backpressure, so the sweep stalls.
  - On rec_valid&&rec_ready: vec_count += 1.
    - If i == 2^N_IN-1: next state DONE (done=1, busy=0, rec_valid=0).
    - Otherwise: i += 1 and return to APPLY with the next vector.
- Throughput with rec_ready=1: SETTLE+1 cycles per vector. Total latency from start to done = 1 + 2^N_IN*(SETTLE+1) cycles.
- Index i is N_IN+1 bits, so 2^N_IN-1 is detected without wrap. vec_out never wraps past the final vector.
- abort while busy:
  - Next state DONE with aborted=1, done=0, rec_valid=0.
  - A record handshaking in the same cycle is still counted; signature freezes.
  - abort while not busy is ignored.
- start while busy is ignored. start and abort in the same cycle: abort wins if busy, start wins if not busy.
- In DONE, vec_out holds the last applied vector until the next start.

Test Plan:
- N_IN=2, SETTLE=1, mode=0, DUT=XOR, rec_ready=1:
  - records (00,0) (01,1) (10,1) (11,0);
  - signature=16'h0006, vec_count=4;
  - done asserts 9 cycles after start.
- Same, mode=1: vec_out sequence 00,01,11,10; responses 0,1,0,1; signature=16'h0005.
- N_IN=5, SETTLE=3, DUT=AND-of-all, rec_ready=1:
  - 32 records, only vector 11111 has resp=1;
  - done exactly 1+32*4=129 cycles after start; vec_count=32.
- Backpressure, N_IN=2: rec_ready low for 5 cycles on the record for vector 01:
  - rec_valid held with stable rec_vec/rec_resp, vec_out frozen at 01;
  - final signature identical to the no-stall run (16'h0006).
- abort asserted while the third record is valid with rec_ready=1:
  - vec_count=3, aborted=1, done=0, busy=0 next cycle;
  - a subsequent start clears aborted and re-sweeps from vector 0.
- reset=0 mid-sweep, then start: all outputs are 0 the cycle after reset; the next sweep reproduces the golden signature.

Source files
------------

// File: rtl/exhaustive_sweep_engine.sv
// Exhaustive input sweep engine: walks all 2^N_IN vectors (binary or Gray order), samples the
// DUT response after SETTLE cycles, streams (vector, response) records and folds them into a MISR.
module exhaustive_sweep_engine #(
    parameter int                N_IN      = 5,
    parameter int                N_OUT     = 1,
    parameter int                SETTLE    = 1,
    parameter int                MISR_W    = 16,
    parameter logic [MISR_W-1:0] MISR_POLY = 16'h1021
) (
    input  logic              CK,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic              abort,
    output logic [N_IN-1:0]   vec_out,
    input  logic [N_OUT-1:0]  dut_resp,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [N_IN-1:0]   rec_vec,
    output logic [N_OUT-1:0]  rec_resp,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [MISR_W-1:0] signature,
    output logic [N_IN:0]     vec_count
);
    localparam int                CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(SETTLE - 1);
    // The index is one bit wider than the vector so the final vector is detected without wrapping.
    localparam logic [N_IN:0]     LAST_IDX = {1'b0, {N_IN{1'b1}}};

    typedef enum logic [1:0] {IDLE, APPLY, EMIT, DONE} state_t;

    state_t           state;
    logic             mode_r;
    logic [N_IN:0]    idx;
    logic [N_IN:0]    idx_next;
    logic [CNT_W-1:0] cnt;

    assign idx_next = idx + 1'b1;

    function automatic logic [N_IN-1:0] order(input logic [N_IN-1:0] i, input logic gray);
        return gray ? (i ^ (i >> 1)) : i;
    endfunction

    function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] sig,
                                                    input logic [N_OUT-1:0]  resp);
        logic [MISR_W-1:0] shifted;
        shifted = {sig[MISR_W-2:0], 1'b0};
        if (sig[MISR_W-1]) shifted = shifted ^ MISR_POLY;
        return shifted ^ MISR_W'(resp);
    endfunction

    always_ff @(posedge CK) begin
        if (!reset) begin
            state     <= IDLE;
            mode_r    <= 1'b0;
            idx       <= '0;
            cnt       <= '0;
            vec_out   <= '0;
            rec_valid <= 1'b0;
            rec_vec   <= '0;
            rec_resp  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            signature <= '0;
            vec_count <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= APPLY;
                        mode_r    <= mode;
                        idx       <= '0;
                        cnt       <= '0;
                        vec_out   <= order('0, mode);
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        aborted   <= 1'b0;
                        signature <= '0;
                        vec_count <= '0;
                    end
                end
                APPLY: begin
                    if (abort) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        aborted <= 1'b1;
                    end else if (cnt == LAST_CNT) begin
                        state     <= EMIT;
                        rec_valid <= 1'b1;
                        rec_vec   <= vec_out;
                        rec_resp  <= dut_resp;
                        signature <= misr_step(signature, dut_resp);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                EMIT: begin
                    // A record accepted in the same cycle as an abort still counts.
                    if (rec_ready) vec_count <= vec_count + 1'b1;
                    if (abort) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        aborted   <= 1'b1;
                        rec_valid <= 1'b0;
                    end else if (rec_ready) begin
                        rec_valid <= 1'b0;
                        if (idx == LAST_IDX) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state   <= APPLY;
                            idx     <= idx_next;
                            cnt     <= '0;
                            vec_out <= order(idx_next[N_IN-1:0], mode_r);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_exhaustive_sweep_engine.sv
// Bench for exhaustive_sweep_engine: a 2-input XOR instance checked every cycle against a
// behavioural sweep model, plus a 5-input AND instance checked for order, latency and signature.
module tb_exhaustive_sweep_engine;
    localparam int NA = 2;
    localparam int SA = 1;
    localparam int NB = 5;
    localparam int SB = 3;
    localparam logic [15:0] POLY = 16'h1021;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic          start_a, mode_a, abort_a, ready_a;
    logic [NA-1:0] vec_a, rvec_a;
    logic          resp_a, rresp_a, rvalid_a, busy_a, done_a, aborted_a;
    logic [15:0]   sig_a;
    logic [NA:0]   cnt_a;

    logic          start_b, mode_b, abort_b, ready_b;
    logic [NB-1:0] vec_b, rvec_b;
    logic          resp_b, rresp_b, rvalid_b, busy_b, done_b, aborted_b;
    logic [15:0]   sig_b;
    logic [NB:0]   cnt_b;

    assign resp_a = ^vec_a;
    assign resp_b = &vec_b;

    exhaustive_sweep_engine #(.N_IN(NA), .N_OUT(1), .SETTLE(SA), .MISR_W(16), .MISR_POLY(POLY)) dut_a (
        .CK(clk), .reset(reset), .start(start_a), .mode(mode_a), .abort(abort_a),
        .vec_out(vec_a), .dut_resp(resp_a), .rec_valid(rvalid_a), .rec_ready(ready_a),
        .rec_vec(rvec_a), .rec_resp(rresp_a), .busy(busy_a), .done(done_a),
        .aborted(aborted_a), .signature(sig_a), .vec_count(cnt_a)
    );

    exhaustive_sweep_engine #(.N_IN(NB), .N_OUT(1), .SETTLE(SB), .MISR_W(16), .MISR_POLY(POLY)) dut_b (
        .CK(clk), .reset(reset), .start(start_b), .mode(mode_b), .abort(abort_b),
        .vec_out(vec_b), .dut_resp(resp_b), .rec_valid(rvalid_b), .rec_ready(ready_b),
        .rec_vec(rvec_b), .rec_resp(rresp_b), .busy(busy_b), .done(done_b),
        .aborted(aborted_b), .signature(sig_b), .vec_count(cnt_b)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int ord(input int k, input bit gray);
        return gray ? (k ^ (k >> 1)) : k;
    endfunction

    function automatic logic [15:0] fold(input logic [15:0] s, input logic r);
        logic [15:0] t;
        t = {s[14:0], 1'b0};
        if (s[15]) t = t ^ POLY;
        return t ^ {15'b0, r};
    endfunction

    // Behavioural model of instance A: vector k is held, it becomes a record after SA
    // held cycles, and the record is retired on a ready cycle.
    bit          m_active, m_done, m_aborted, m_mode;
    int          m_k, m_w, m_count;
    logic [15:0] m_sig;
    logic [NA-1:0] m_vec, m_rvec;
    logic        m_rresp;

    always @(posedge clk) begin
        bit valid;
        if (!reset) begin
            m_active = 0; m_done = 0; m_aborted = 0; m_mode = 0;
            m_k = 0; m_w = 0; m_count = 0; m_sig = '0; m_vec = '0; m_rvec = '0; m_rresp = 0;
        end else if (m_active) begin
            valid = (m_w >= SA);
            if (abort_a) begin
                if (valid && ready_a) m_count++;
                m_active = 0;
                m_aborted = 1;
            end else if (!valid) begin
                m_w++;
                if (m_w == SA) begin
                    m_rvec  = m_vec;
                    m_rresp = ^m_vec;
                    m_sig   = fold(m_sig, ^m_vec);
                end
            end else if (ready_a) begin
                m_count++;
                if (m_k == (1 << NA) - 1) begin
                    m_active = 0;
                    m_done = 1;
                end else begin
                    m_k++;
                    m_w = 0;
                    m_vec = NA'(ord(m_k, m_mode));
                end
            end
        end else if (start_a) begin
            m_active = 1; m_done = 0; m_aborted = 0; m_mode = mode_a;
            m_k = 0; m_w = 0; m_count = 0; m_sig = '0;
            m_vec = NA'(ord(0, mode_a));
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_busy", busy_a, m_active);
            check("model_done", done_a, m_done);
            check("model_aborted", aborted_a, m_aborted);
            check("model_rec_valid", rvalid_a, m_active && (m_w >= SA));
            check("model_vec_out", vec_a, m_vec);
            check("model_vec_count", cnt_a, m_count);
            check("model_signature", sig_a, m_sig);
            if (m_active && (m_w >= SA)) begin
                check("model_rec_vec", rvec_a, m_rvec);
                check("model_rec_resp", rresp_a, m_rresp);
            end
        end
    end

    logic [NA-1:0] cap_v [8];
    logic          cap_r [8];
    int            cap_n;

    task automatic sweep_a(input bit md, output int cyc);
        cap_n = 0;
        mode_a = md;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        cyc = 1;
        while (!done_a && cyc < 200) begin
            if (rvalid_a && ready_a && cap_n < 8) begin
                cap_v[cap_n] = rvec_a;
                cap_r[cap_n] = rresp_a;
                cap_n++;
            end
            @(negedge clk);
            cyc++;
        end
        check("sweep_a_finished", done_a, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, n, ones, nexp;
        int bin_v[4];
        int bin_r[4];
        int gray_v[4];
        int gray_r[4];
        bin_v = '{0, 1, 2, 3}; bin_r = '{0, 1, 1, 0};
        gray_v = '{0, 1, 3, 2}; gray_r = '{0, 1, 0, 1};

        reset = 1'b0;
        start_a = 0; mode_a = 0; abort_a = 0; ready_a = 1;
        start_b = 0; mode_b = 0; abort_b = 0; ready_b = 1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        chk_en = 1'b1;

        check("reset_busy_a", busy_a, 0);
        check("reset_vec_a", vec_a, 0);
        check("reset_sig_a", sig_a, 0);
        check("reset_cnt_b", cnt_b, 0);
        check("reset_done_b", done_b, 0);

        // Binary order, XOR DUT
        sweep_a(1'b0, cyc);
        check("bin_done_latency", cyc, 9);
        check("bin_signature", sig_a, 16'h0006);
        check("bin_vec_count", cnt_a, 4);
        check("bin_record_count", cap_n, 4);
        for (int i = 0; i < 4; i++) begin
            check("bin_rec_vec", cap_v[i], bin_v[i]);
            check("bin_rec_resp", cap_r[i], bin_r[i]);
        end

        // Gray order
        sweep_a(1'b1, cyc);
        check("gray_signature", sig_a, 16'h0005);
        check("gray_done_latency", cyc, 9);
        for (int i = 0; i < 4; i++) begin
            check("gray_rec_vec", cap_v[i], gray_v[i]);
            check("gray_rec_resp", cap_r[i], gray_r[i]);
        end

        // Backpressure on the record for vector 01
        mode_a = 0; start_a = 1; @(negedge clk); start_a = 0;
        n = 0;
        while (!(rvalid_a && rvec_a == 2'b01) && n < 20) begin @(negedge clk); n++; end
        check("stall_found_record", rvalid_a && rvec_a == 2'b01, 1);
        ready_a = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", rvalid_a, 1);
            check("stall_rec_vec", rvec_a, 2'b01);
            check("stall_rec_resp", rresp_a, 1);
            check("stall_vec_out", vec_a, 2'b01);
        end
        ready_a = 1;
        n = 0;
        while (!done_a && n < 50) begin @(negedge clk); n++; end
        check("stall_done", done_a, 1);
        check("stall_signature", sig_a, 16'h0006);

        // Abort while the third record is being accepted
        mode_a = 0; start_a = 1; @(negedge clk); start_a = 0;
        n = 0; nexp = 0;
        while (n < 50) begin
            if (rvalid_a) begin
                nexp++;
                if (nexp == 3) break;
            end
            @(negedge clk); n++;
        end
        abort_a = 1; @(negedge clk); abort_a = 0;
        check("abort_vec_count", cnt_a, 3);
        check("abort_aborted", aborted_a, 1);
        check("abort_done", done_a, 0);
        check("abort_busy", busy_a, 0);
        start_a = 1; @(negedge clk); start_a = 0;
        check("restart_aborted_clear", aborted_a, 0);
        check("restart_vec0", vec_a, 0);
        check("restart_busy", busy_a, 1);
        n = 0;
        while (!done_a && n < 50) begin @(negedge clk); n++; end
        check("restart_signature", sig_a, 16'h0006);

        // Reset mid-sweep
        start_a = 1; @(negedge clk); start_a = 0;
        repeat (4) @(negedge clk);
        reset = 0; @(negedge clk); reset = 1;
        check("midreset_busy", busy_a, 0);
        check("midreset_valid", rvalid_a, 0);
        check("midreset_vec", vec_a, 0);
        check("midreset_sig", sig_a, 0);
        check("midreset_cnt", cnt_a, 0);
        sweep_a(1'b0, cyc);
        check("midreset_golden", sig_a, 16'h0006);
        check("midreset_count", cnt_a, 4);

        // Instance B: 5-input AND, SETTLE=3
        mode_b = 0; start_b = 1; @(negedge clk); start_b = 0;
        cyc = 1; ones = 0; nexp = 0;
        while (!done_b && cyc < 400) begin
            if (rvalid_b) begin
                check("b_rec_order", rvec_b, nexp);
                check("b_rec_resp", rresp_b, &rvec_b);
                if (rresp_b) ones++;
                nexp++;
            end
            @(negedge clk); cyc++;
        end
        check("b_done", done_b, 1);
        check("b_latency", cyc, 129);
        check("b_vec_count", cnt_b, 32);
        check("b_records", nexp, 32);
        check("b_ones", ones, 1);
        check("b_signature", sig_b, 16'h0001);

        // Randomized traffic on instance A against the model
        for (int c = 0; c < 3000; c++) begin
            ready_a = ($urandom_range(0, 3) != 0);
            start_a = ($urandom_range(0, 11) == 0);
            abort_a = ($urandom_range(0, 40) == 0);
            mode_a  = $urandom_range(0, 1);
            reset   = ($urandom_range(0, 400) != 0);
            @(negedge clk);
        end
        start_a = 0; abort_a = 0; reset = 1; ready_a = 1;
        sweep_a(1'b1, cyc);
        check("final_gray_signature", sig_a, 16'h0005);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
